// File: rtl/mrsc_pipe_encoder_if.sv
// Handshake bundle for mrsc_pipe_encoder: upstream word stream in, codeword stream out.
// The master side drives words and downstream ready; the slave side is the encoder.
interface mrsc_pipe_encoder_if #(
    parameter int COLS  = 4,
    parameter int CNT_W = 16
);
    logic [4*COLS-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic [8*COLS-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  word_cnt;

    modport master (
        output data_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  word_cnt
    );

    modport slave (
        input  data_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output data_out,
        output out_valid,
        output word_cnt
    );
endinterface

// File: rtl/mrsc_pipe_encoder.sv
// Two-stage pipelined encoder for a 4 x COLS bit matrix: row check bits, column and
// diagonal parity interleaved into four 2*COLS row blocks, with a delivered-word counter.
module mrsc_pipe_encoder #(
    parameter int COLS  = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mrsc_pipe_encoder_if.slave  bus
);
    localparam int H  = COLS / 2;
    localparam int DW = 4 * COLS;
    localparam int CW = 8 * COLS;
    localparam int BW = 2 * COLS;

    logic              a_valid;
    logic [DW-1:0]     a_data;
    logic              out_valid_q;
    logic [CW-1:0]     data_out_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic              b_adv;
    logic              a_adv;
    logic              in_ready_c;
    logic [COLS-1:0]   s [4];
    logic [COLS-1:0]   col_par;
    logic [COLS-1:0]   diag_par;
    logic [CW-1:0]     codeword;

    assign b_adv      = !out_valid_q || bus.out_ready;
    assign a_adv      = a_valid && b_adv;
    assign in_ready_c = !a_valid || b_adv;

    // Unpack stage A into s[row][col]; column 0 sits at the MSB end of each row.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            s[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                s[r][c] = a_data[(4-r)*COLS-1-c];
            end
        end
    end

    // Diagonal parity pairs each column with its neighbour (c^1) on odd rows only.
    always_comb begin
        col_par  = '0;
        diag_par = '0;
        codeword = '0;
        for (int c = 0; c < COLS; c++) begin
            col_par[c]  = s[0][c] ^ s[1][c] ^ s[2][c] ^ s[3][c];
            diag_par[c] = s[0][c] ^ s[1][c^1] ^ s[2][c] ^ s[3][c^1];
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < COLS; c++) begin
                codeword[(4-r)*BW-1-c] = s[r][c];
            end
            for (int i = 0; i < H; i++) begin
                codeword[(4-r)*BW-1-COLS-i]   = (r < 2) ? diag_par[2*i + (r % 2)]
                                                        : col_par[2*i + (r % 2)];
                codeword[(4-r)*BW-1-COLS-H-i] = s[r][i] ^ s[r][i+H];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else if (in_ready_c) begin
            a_valid <= bus.in_valid;
            if (bus.in_valid) begin
                a_data <= bus.data_in;
            end
        end
    end

    // Stage B holds while the consumer stalls; an empty stage A drains into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            if (b_adv) begin
                out_valid_q <= a_adv;
                if (a_adv) begin
                    data_out_q <= codeword;
                end
            end
            if (out_valid_q && bus.out_ready) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_mrsc_pipe_encoder.sv
// Bench for mrsc_pipe_encoder: known vectors, stall/reset/wrap sequences and random
// traffic checked against an arithmetic model of the encoding through a scoreboard.
module tb_mrsc_pipe_encoder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   exp_cnt;
    logic rand_done;
    logic [31:0] sb_q [$];

    typedef struct {
        logic [15:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] b2b_in  [3];
    logic [31:0] b2b_out [3];
    logic [15:0] stall_w [3];

    mrsc_pipe_encoder_if #(.COLS(4), .CNT_W(16)) bus ();
    mrsc_pipe_encoder_if #(.COLS(4), .CNT_W(4))  bus2 ();

    assign bus2.data_in   = bus.data_in;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.out_ready = bus.out_ready;

    mrsc_pipe_encoder #(.COLS(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mrsc_pipe_encoder #(.COLS(4), .CNT_W(4)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_encode(input logic [15:0] w);
        int s [4][4];
        int par [4];
        int dia [4];
        int bits [8];
        int idx;
        logic [31:0] cw;
        cw = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = w[15 - 4*r - c] ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            par[c] = (s[0][c] + s[1][c] + s[2][c] + s[3][c]) % 2;
            dia[c] = (s[0][c] + s[1][c^1] + s[2][c] + s[3][c^1]) % 2;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) bits[c] = s[r][c];
            for (int i = 0; i < 2; i++) begin
                idx         = 2*i + (r % 2);
                bits[4 + i] = (r < 2) ? dia[idx] : par[idx];
                bits[6 + i] = (s[r][i] + s[r][i+2]) % 2;
            end
            for (int j = 0; j < 8; j++) cw = (cw << 1) | 32'(bits[j]);
        end
        return cw;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a word on the input until the encoder takes it; in_valid stays high afterwards.
    task automatic applyStimulus(input logic [15:0] w);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.data_in  = w;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 for word %h", w);
        end
    endtask

    task automatic wait_drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick(1);
            if (!bus.out_valid && sb_q.size() == 0) break;
        end
        checkOutput({name, "_queue"}, 64'(sb_q.size()), 64'(0));
        checkOutput({name, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    endtask

    // Scoreboard: every output transfer must match the oldest accepted word's encoding.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL scoreboard_extra: got %h expected no output", bus.data_out);
                    end else begin
                        exp = sb_q.pop_front();
                        checkOutput("scoreboard", 64'(bus.data_out), 64'(exp));
                    end
                end
                if (bus.in_valid && bus.in_ready) sb_q.push_back(ref_encode(bus.data_in));
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            sb_q.delete();
        end
    end

    initial begin
        int idx;
        logic acc;
        tests = 0;
        fails = 0;
        exp_cnt = 0;
        rand_done = 1'b0;

        vecs[0] = '{din: 16'hFFFF, dout: 32'hF0F0F0F0};
        vecs[1] = '{din: 16'h8000, dout: 32'h8A000800};
        vecs[2] = '{din: 16'h4000, dout: 32'h41080008};
        vecs[3] = '{din: 16'h0800, dout: 32'h008A0800};
        vecs[4] = '{din: 16'h0001, dout: 32'h04000015};
        vecs[5] = '{din: 16'h0010, dout: 32'h00041104};
        b2b_in  = '{16'h8000, 16'h4000, 16'h0800};
        b2b_out = '{32'h8A000800, 32'h41080008, 32'h008A0800};
        stall_w = '{16'h1234, 16'hBEEF, 16'h0F0F};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        tick(3);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_data_out", 64'(bus.data_out), 64'(0));
        checkOutput("rst_word_cnt", 64'(bus.word_cnt), 64'(0));
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].din);
            bus.in_valid = 1'b0;
            tick(1);
            checkOutput($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(1));
            checkOutput($sformatf("vec%0d_data", i), 64'(bus.data_out), 64'(vecs[i].dout));
            tick(1);
            checkOutput($sformatf("vec%0d_bubble", i), 64'(bus.out_valid), 64'(0));
            exp_cnt++;
        end
        checkOutput("vec_word_cnt", 64'(bus.word_cnt), 64'(exp_cnt));

        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.data_in = b2b_in[k];
            tick(1);
            if (k >= 1) checkOutput($sformatf("b2b_out%0d", k-1), 64'(bus.data_out), 64'(b2b_out[k-1]));
        end
        bus.in_valid = 1'b0;
        tick(1);
        checkOutput("b2b_out2", 64'(bus.data_out), 64'(b2b_out[2]));
        tick(1);
        checkOutput("b2b_bubble", 64'(bus.out_valid), 64'(0));
        exp_cnt += 3;

        bus.out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = stall_w[idx];
            @(negedge clk);
            acc = bus.in_ready;
            tick(1);
            if (acc) idx++;
        end
        checkOutput("stall_accepted", 64'(idx), 64'(2));
        for (int cyc = 0; cyc < 3; cyc++) begin
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'(0));
            checkOutput("stall_out_valid", 64'(bus.out_valid), 64'(1));
            checkOutput("stall_data", 64'(bus.data_out), 64'(ref_encode(stall_w[0])));
            tick(1);
        end
        bus.out_ready = 1'b1;
        applyStimulus(stall_w[2]);
        wait_drain("stall_drain");
        exp_cnt += 3;
        checkOutput("stall_word_cnt", 64'(bus.word_cnt), 64'(exp_cnt));

        fork
            begin
                int idle;
                for (int n = 0; n < 10000; n++) begin
                    idle = $urandom_range(0, 2);
                    if (idle > 0) begin
                        bus.in_valid = 1'b0;
                        bus.data_in  = 16'($urandom);
                        tick(idle);
                    end
                    applyStimulus(16'($urandom));
                end
                bus.in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain("rand_drain");
        exp_cnt += 10000;
        checkOutput("rand_word_cnt", 64'(bus.word_cnt), 64'(exp_cnt));

        // Reset lands mid-cycle with both stages full and the consumer stalled.
        bus.out_ready = 1'b0;
        applyStimulus(16'hA5A5);
        applyStimulus(16'h5A5A);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("midrst_word_cnt", 64'(bus.word_cnt), 64'(0));
        checkOutput("midrst_wrap_cnt", 64'(bus2.word_cnt), 64'(0));
        checkOutput("midrst_data_out", 64'(bus.data_out), 64'(0));
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 16'hC3E1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("post_rst_no_stale", 64'(bus.out_valid), 64'(0));
        tick(1);
        checkOutput("first_xfer_valid", 64'(bus.out_valid), 64'(1));
        checkOutput("first_xfer_data", 64'(bus.data_out), 64'(ref_encode(16'hC3E1)));

        for (int n = 0; n < 16; n++) applyStimulus(16'($urandom));
        wait_drain("wrap_drain");
        checkOutput("wrap_cnt16", 64'(bus.word_cnt), 64'(17));
        checkOutput("wrap_cnt4", 64'(bus2.word_cnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
